apb_protocol_checker: RTL

Synthesizable, parametrised APB3 protocol checker that passively snoops one APB bus with NSEL slave selects. It is the next generation of the team's bench-only APB assertion set, and it differs in three ways. Its checks are sequential and stateful: phase ordering, signal stability and wait-state timeout. Violations are reported as registered pulse and sticky flags instead of simulator messages. It also keeps transfer and error counters. It sits alongside the APB master/slave fabric in both DUT and emulation builds and drives only observation outputs.

---
 rtl/apb_chk_pkg.sv | 19 +
 rtl/apb_chk_sat_cnt.sv | 23 ++
 rtl/apb_protocol_checker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/apb_chk_pkg.sv
// apb_chk_pkg: shared types for the APB3 protocol checker.
// Phase classification enum and error-bit positions.
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT
  } state_t;

  localparam int ERR_W            = 6;
  localparam int ERR_SEL_MULTI    = 0;
  localparam int ERR_EN_NO_SETUP  = 1;
  localparam int ERR_SETUP_NO_EN  = 2;
  localparam int ERR_UNSTABLE     = 3;
  localparam int ERR_TIMEOUT      = 4;
  localparam int ERR_SLVERR_STRAY = 5;

endpackage

// File: rtl/apb_chk_sat_cnt.sv
// apb_chk_sat_cnt: W-bit saturating up-counter.
// Ports: clk, rst_n, inc (+1), clr (sync zero; inc wins to 1), q.
module apb_chk_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= W'(inc);
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// apb_protocol_checker: passive APB3 snooper; bus in, err_pulse/
// err_sticky/irq flags and xfer/slverr/max_wait statistics out.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int NSEL     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [NSEL-1:0]   psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic              clr,
  input  logic [ERR_W-1:0]  err_mask,
  output logic [ERR_W-1:0]  err_pulse,
  output logic [ERR_W-1:0]  err_sticky,
  output logic              irq,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  slverr_cnt,
  output logic [CNT_W-1:0]  max_wait
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int MW = (WW > CNT_W) ? WW : CNT_W;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  state_t            state_q;
  state_t            state_d;
  logic [NSEL-1:0]   sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WW-1:0]     wait_cnt;
  logic [WW-1:0]     wait_d;
  logic [ERR_W-1:0]  pulse_d;
  logic              cap;
  logic              done;
  logic              multi;
  logic              one;
  logic              unstable;
  logic [MW-1:0]     wait_ext;
  logic [CNT_W-1:0]  wait_sat;

  assign multi = $countones(psel) > 1;
  assign one   = $countones(psel) == 1;

  // penable falling mid-access is treated as an instability too
  assign unstable = !penable
                 || (psel != sel_q)
                 || (paddr != addr_q)
                 || (pwrite != write_q)
                 || (write_q && (pwdata != wdata_q));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    pulse_d = '0;
    cap     = 1'b0;
    done    = 1'b0;
    pulse_d[ERR_SEL_MULTI] = multi;
    unique case (state_q)
      IDLE: begin
        if (penable) begin
          pulse_d[ERR_EN_NO_SETUP] = 1'b1;
        end else if (one) begin
          cap     = 1'b1;
          state_d = SETUP;
          wait_d  = '0;
        end
      end
      SETUP, WAIT: begin
        state_d = IDLE;
        if ((state_q == SETUP) && !penable) begin
          pulse_d[ERR_SETUP_NO_EN] = 1'b1;
        end else if (unstable) begin
          pulse_d[ERR_UNSTABLE] = 1'b1;
        end else if (pready) begin
          done = 1'b1;
        end else begin
          state_d = WAIT;
          if (wait_cnt != WMAX) begin
            wait_d = wait_cnt + 1'b1;
          end
          // fires only on the step into WMAX, never while saturated
          pulse_d[ERR_TIMEOUT] = (wait_cnt == WMAX - 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
    pulse_d[ERR_SLVERR_STRAY] = pslverr & ~done;
  end

  assign wait_ext = MW'(wait_cnt);
  assign wait_sat = (wait_ext > MW'({CNT_W{1'b1}}))
                  ? '1 : CNT_W'(wait_ext);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (cap) begin
        sel_q   <= psel;
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      irq        <= 1'b0;
      max_wait   <= '0;
    end else begin
      err_pulse  <= pulse_d;
      err_sticky <= clr ? pulse_d : (err_sticky | pulse_d);
      irq        <= |(err_sticky & err_mask);
      if (clr) begin
        max_wait <= done ? wait_sat : '0;
      end else if (done && (wait_sat > max_wait)) begin
        max_wait <= wait_sat;
      end
    end
  end

  apb_chk_sat_cnt #(.W(CNT_W)) u_xfer (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .inc   (done),
    .clr   (clr),
    .q     (xfer_cnt)
  );

  apb_chk_sat_cnt #(.W(CNT_W)) u_slverr (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .inc   (done & pslverr),
    .clr   (clr),
    .q     (slverr_cnt)
  );

endmodule
